// File: rtl/zone_capacity_ctrl.sv
// rtl/zone_capacity_ctrl.sv - multi-zone occupancy counters with handshaked capacity limits
//
// Purpose: per-zone occupancy counters (enter/leave pulses) bounded by per-zone
// capacity limits. Limits change only via a valid/ready request that is checked
// against CAP_MAX and answered with a one-cycle status response.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   en                         global enable for counting and request acceptance
//   enter, leave [NUM_ZONES]   per-zone arrival / departure pulses
//   req_valid, req_ready       limit-change request handshake
//   req_zone, req_cap          target zone and desired limit
//   resp_valid                 one-cycle response strobe
//   resp_status                00 APPLIED, 01 APPLIED_OVER, 10 REJECTED, 11 BAD_ZONE
//   resp_cap                   limit in force after the request (0 for BAD_ZONE)
//   occ, cap_lim               packed per-zone occupancy / limits, zone z at [z*WIDTH +: WIDTH]
//   full, empty, over_cap      per-zone flags from registered state
//   enter_rej                  registered pulse: an enter was refused last cycle
module zone_capacity_ctrl #(
    parameter int WIDTH     = 4,
    parameter int NUM_ZONES = 4,
    parameter int ZONE_W    = 2,
    parameter int CAP_MAX   = 12,
    parameter int CAP_RESET = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NUM_ZONES-1:0]       enter,
    input  logic [NUM_ZONES-1:0]       leave,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ZONE_W-1:0]          req_zone,
    input  logic [WIDTH-1:0]           req_cap,
    output logic                       resp_valid,
    output logic [1:0]                 resp_status,
    output logic [WIDTH-1:0]           resp_cap,
    output logic [NUM_ZONES*WIDTH-1:0] occ,
    output logic [NUM_ZONES*WIDTH-1:0] cap_lim,
    output logic [NUM_ZONES-1:0]       full,
    output logic [NUM_ZONES-1:0]       empty,
    output logic [NUM_ZONES-1:0]       over_cap,
    output logic [NUM_ZONES-1:0]       enter_rej
);

    // One extra bit so NUM_ZONES == 2^ZONE_W is representable.
    localparam logic [ZONE_W:0]  ZONE_LIMIT  = (ZONE_W+1)'(NUM_ZONES);
    localparam logic [WIDTH-1:0] CAP_MAX_W   = WIDTH'(CAP_MAX);
    localparam logic [WIDTH-1:0] CAP_RESET_W = WIDTH'(CAP_RESET);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RESP} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [WIDTH-1:0]       occ_r [NUM_ZONES];
    logic [WIDTH-1:0]       cap_r [NUM_ZONES];
    logic [NUM_ZONES-1:0]   rej_r;
    logic [ZONE_W-1:0]      lat_zone;
    logic [WIDTH-1:0]       lat_cap;
    logic [1:0]             status_r;
    logic [WIDTH-1:0]       resp_cap_r;

    logic                   zone_bad;
    logic                   cap_bad;
    logic                   write_en;
    logic [NUM_ZONES-1:0]   zone_hit;
    logic [WIDTH-1:0]       sel_occ;
    logic [WIDTH-1:0]       sel_cap;
    logic [1:0]             eval_status;
    logic [WIDTH-1:0]       eval_cap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid && en) state_nxt = S_EVAL;
            S_EVAL:  state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == S_IDLE) && en;
        resp_valid = (state == S_RESP);
    end

    // Request evaluation uses the latched request and pre-edge zone state.
    always_comb begin
        zone_bad = {1'b0, lat_zone} >= ZONE_LIMIT;
        cap_bad  = lat_cap > CAP_MAX_W;
        sel_occ  = '0;
        sel_cap  = '0;
        zone_hit = '0;
        for (int z = 0; z < NUM_ZONES; z++) begin
            if (lat_zone == ZONE_W'(z)) begin
                sel_occ     = occ_r[z];
                sel_cap     = cap_r[z];
                zone_hit[z] = 1'b1;
            end
        end
        write_en = (state == S_EVAL) && !zone_bad && !cap_bad;
        if (zone_bad) begin
            eval_status = 2'b11;
            eval_cap    = '0;
        end else if (cap_bad) begin
            eval_status = 2'b10;
            eval_cap    = sel_cap;
        end else begin
            eval_status = (sel_occ > lat_cap) ? 2'b01 : 2'b00;
            eval_cap    = lat_cap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_zone   <= '0;
            lat_cap    <= '0;
            status_r   <= '0;
            resp_cap_r <= '0;
        end else begin
            if (state == S_IDLE && req_valid && en) begin
                lat_zone <= req_zone;
                lat_cap  <= req_cap;
            end
            if (state == S_EVAL) begin
                status_r   <= eval_status;
                resp_cap_r <= eval_cap;
            end
        end
    end

    // Counters compare against the registered limit; a limit written on the
    // same edge only affects the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rej_r <= '0;
            for (int z = 0; z < NUM_ZONES; z++) begin
                occ_r[z] <= '0;
                cap_r[z] <= CAP_RESET_W;
            end
        end else begin
            rej_r <= '0;
            for (int z = 0; z < NUM_ZONES; z++) begin
                if (en && enter[z] && !leave[z]) begin
                    if (occ_r[z] < cap_r[z]) begin
                        occ_r[z] <= occ_r[z] + 1'b1;
                    end else begin
                        rej_r[z] <= 1'b1;
                    end
                end else if (en && leave[z] && !enter[z] && occ_r[z] != '0) begin
                    occ_r[z] <= occ_r[z] - 1'b1;
                end
                if (write_en && zone_hit[z]) begin
                    cap_r[z] <= lat_cap;
                end
            end
        end
    end

    always_comb begin
        resp_status = status_r;
        resp_cap    = resp_cap_r;
        enter_rej   = rej_r;
        occ         = '0;
        cap_lim     = '0;
        full        = '0;
        empty       = '0;
        over_cap    = '0;
        for (int z = 0; z < NUM_ZONES; z++) begin
            occ[z*WIDTH +: WIDTH]     = occ_r[z];
            cap_lim[z*WIDTH +: WIDTH] = cap_r[z];
            full[z]                   = occ_r[z] >= cap_r[z];
            empty[z]                  = occ_r[z] == '0;
            over_cap[z]               = occ_r[z] > cap_r[z];
        end
    end

endmodule

// File: tb/tb_zone_capacity_ctrl.sv
// tb/tb_zone_capacity_ctrl.sv - self-checking bench for zone_capacity_ctrl
module tb_zone_capacity_ctrl;

    localparam int W    = 4;
    localparam int NZ   = 4;
    localparam int ZW   = 3;
    localparam int CMAX = 12;
    localparam int CRST = 12;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [NZ-1:0]     enter;
    logic [NZ-1:0]     leave;
    logic              req_valid;
    logic              req_ready;
    logic [ZW-1:0]     req_zone;
    logic [W-1:0]      req_cap;
    logic              resp_valid;
    logic [1:0]        resp_status;
    logic [W-1:0]      resp_cap;
    logic [NZ*W-1:0]   occ;
    logic [NZ*W-1:0]   cap_lim;
    logic [NZ-1:0]     full;
    logic [NZ-1:0]     empty;
    logic [NZ-1:0]     over_cap;
    logic [NZ-1:0]     enter_rej;

    zone_capacity_ctrl #(
        .WIDTH(W), .NUM_ZONES(NZ), .ZONE_W(ZW), .CAP_MAX(CMAX), .CAP_RESET(CRST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .enter(enter), .leave(leave),
        .req_valid(req_valid), .req_ready(req_ready), .req_zone(req_zone),
        .req_cap(req_cap), .resp_valid(resp_valid), .resp_status(resp_status),
        .resp_cap(resp_cap), .occ(occ), .cap_lim(cap_lim), .full(full),
        .empty(empty), .over_cap(over_cap), .enter_rej(enter_rej)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain integers per zone plus the age of the
    // in-flight request (0 none, 1 decision pending, 2 response showing).
    int m_occ [NZ];
    int m_cap [NZ];
    int m_rej [NZ];
    int m_age;
    int m_zone;
    int m_req;
    int m_st;
    int m_rc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int old_occ [NZ];
        int old_cap [NZ];
        for (int z = 0; z < NZ; z++) begin
            old_occ[z] = m_occ[z];
            old_cap[z] = m_cap[z];
        end
        if (!rst_n) begin
            for (int z = 0; z < NZ; z++) begin
                m_occ[z] = 0;
                m_cap[z] = CRST;
                m_rej[z] = 0;
            end
            m_age = 0;
            m_st  = 0;
            m_rc  = 0;
        end else begin
            for (int z = 0; z < NZ; z++) begin
                m_rej[z] = 0;
                if (en && enter[z] && !leave[z]) begin
                    if (old_occ[z] < old_cap[z]) m_occ[z] = old_occ[z] + 1;
                    else m_rej[z] = 1;
                end else if (en && leave[z] && !enter[z] && old_occ[z] > 0) begin
                    m_occ[z] = old_occ[z] - 1;
                end
            end
            if (m_age == 2) begin
                m_age = 0;
            end else if (m_age == 1) begin
                if (m_zone >= NZ) begin
                    m_st = 3; m_rc = 0;
                end else if (m_req > CMAX) begin
                    m_st = 2; m_rc = old_cap[m_zone];
                end else begin
                    m_cap[m_zone] = m_req;
                    m_st = (old_occ[m_zone] > m_req) ? 1 : 0;
                    m_rc = m_req;
                end
                m_age = 2;
            end else if (en && req_valid) begin
                m_zone = int'(req_zone);
                m_req  = int'(req_cap);
                m_age  = 1;
            end
        end
    endtask

    task automatic check_all();
        for (int z = 0; z < NZ; z++) begin
            chk($sformatf("occ[%0d]", z), int'(occ[z*W +: W]), m_occ[z]);
            chk($sformatf("cap_lim[%0d]", z), int'(cap_lim[z*W +: W]), m_cap[z]);
            chk($sformatf("full[%0d]", z), int'(full[z]), int'(m_occ[z] >= m_cap[z]));
            chk($sformatf("empty[%0d]", z), int'(empty[z]), int'(m_occ[z] == 0));
            chk($sformatf("over_cap[%0d]", z), int'(over_cap[z]), int'(m_occ[z] > m_cap[z]));
            chk($sformatf("enter_rej[%0d]", z), int'(enter_rej[z]), m_rej[z]);
        end
        chk("req_ready", int'(req_ready), int'(en && m_age == 0));
        chk("resp_valid", int'(resp_valid), int'(m_age == 2));
        chk("resp_status", int'(resp_status), m_st);
        chk("resp_cap", int'(resp_cap), m_rc);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_req(input int zone, input int cap,
                          output int st, output int rc, output int lat);
        st  = -1;
        rc  = -1;
        lat = -1;
        req_valid = 1'b1;
        req_zone  = ZW'(zone);
        req_cap   = W'(cap);
        cycle();
        req_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (resp_valid) begin
                st  = int'(resp_status);
                rc  = int'(resp_cap);
                lat = i;
                break;
            end
            cycle();
        end
        chk("resp_latency", lat, 2);
    endtask

    int st, rc, lat;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int z = 0; z < NZ; z++) begin
            m_occ[z] = 0; m_cap[z] = CRST; m_rej[z] = 0;
        end
        m_age = 0; m_zone = 0; m_req = 0; m_st = 0; m_rc = 0;
        rst_n = 1'b0; en = 1'b0; enter = '0; leave = '0;
        req_valid = 1'b0; req_zone = '0; req_cap = '0;
        cycle();
        cycle();
        rst_n = 1'b1;
        en    = 1'b1;
        cycle();
        chk("lit_reset_cap", int'(cap_lim), 16'hCCCC);
        chk("lit_reset_occ", int'(occ), 0);
        chk("lit_reset_empty", int'(empty), 4'hF);

        enter = 4'b0010;
        repeat (5) cycle();
        enter = '0;
        cycle();
        chk("lit_z1_occ", int'(occ[7:4]), 5);
        chk("lit_z1_empty", int'(empty[1]), 0);
        chk("lit_z0_occ", int'(occ[3:0]), 0);

        enter = 4'b0001;
        repeat (12) cycle();
        chk("lit_z0_full", int'(full[0]), 1);
        cycle();
        chk("lit_z0_refused_occ", int'(occ[3:0]), 12);
        chk("lit_z0_enter_rej", int'(enter_rej), 4'b0001);
        leave = 4'b0001;
        cycle();
        chk("lit_z0_enter_leave_occ", int'(occ[3:0]), 12);
        chk("lit_z0_enter_leave_rej", int'(enter_rej), 0);
        enter = '0;
        leave = '0;

        enter = 4'b0100;
        repeat (3) cycle();
        enter = '0;
        do_req(2, 7, st, rc, lat);
        chk("lit_req_z2_status", st, 0);
        chk("lit_req_z2_cap", rc, 7);
        chk("lit_req_z2_lim", int'(cap_lim[11:8]), 7);
        cycle();

        do_req(0, 8, st, rc, lat);
        chk("lit_req_z0_status", st, 1);
        chk("lit_req_z0_over", int'(over_cap[0]), 1);
        cycle();
        enter = 4'b0001;
        cycle();
        enter = '0;
        chk("lit_over_enter_rej", int'(enter_rej[0]), 1);
        leave = 4'b0001;
        repeat (4) cycle();
        leave = '0;
        chk("lit_drain_occ", int'(occ[3:0]), 8);
        chk("lit_drain_over", int'(over_cap[0]), 0);
        chk("lit_drain_full", int'(full[0]), 1);

        do_req(0, 13, st, rc, lat);
        chk("lit_rejected_status", st, 2);
        chk("lit_rejected_cap", rc, 8);
        cycle();
        chk("lit_rejected_lim", int'(cap_lim[3:0]), 8);

        do_req(5, 3, st, rc, lat);
        chk("lit_bad_zone_status", st, 3);
        chk("lit_bad_zone_cap", rc, 0);
        cycle();

        enter = 4'b1000;
        repeat (2) cycle();
        enter = '0;
        do_req(3, 0, st, rc, lat);
        chk("lit_cap0_status", st, 1);
        chk("lit_cap0_over", int'(over_cap[3]), 1);
        cycle();

        req_valid = 1'b1; req_zone = 3'd1; req_cap = 4'd3;
        cycle();
        req_valid = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("lit_abort_resp", int'(resp_valid), 0);
        chk("lit_abort_cap", int'(cap_lim), 16'hCCCC);

        en = 1'b0; enter = 4'hF; req_valid = 1'b1; req_zone = '0; req_cap = 4'd5;
        #1;
        chk("lit_en0_ready", int'(req_ready), 0);
        repeat (2) cycle();
        chk("lit_en0_occ", int'(occ), 0);
        chk("lit_en0_resp", int'(resp_valid), 0);
        enter = '0; req_valid = 1'b0; en = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            en        = ($urandom_range(0, 9) != 0);
            enter     = NZ'($urandom);
            leave     = NZ'($urandom & $urandom);
            req_valid = ($urandom_range(0, 2) == 0);
            req_zone  = ZW'($urandom);
            req_cap   = W'($urandom_range(0, 15));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
